uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_sync.sv | 24 ++
 rtl/uart_rx.sv | 121 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states and 8N1 frame constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  // 12 MHz sysclk / 9600 baud
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 1250;

  // 8N1: eight data bits, no parity, one stop bit
  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned IDX_W     = $clog2(DATA_BITS);

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a
// parameterized reset value so an idle-high line does not look like a start bit.
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic sysclk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, single-entry holding register
// (valid/ready handshake), frame-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 sysclk,
  input  logic                 rst,
  input  logic                 uart_txd_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic                 rx_sync;
  rx_state_t            state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shreg;

  uart_sync #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .sysclk(sysclk),
    .rst   (rst),
    .d     (uart_txd_in),
    .q     (rx_sync)
  );

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      // A consumed byte clears valid here; a delivery later in this block
      // overrides the clear so transfer-and-load keeps valid high.
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rx_sync) begin
            state <= START;
            cnt   <= '0;
          end
        end

        START: begin
          if (cnt == HALF_END) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rx_sync ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == BIT_END) begin
            cnt        <= '0;
            shreg[idx] <= rx_sync;
            if (idx == LAST_IDX) begin
              state <= STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (cnt == BIT_END) begin
            cnt <= '0;
            if (rx_sync) begin
              state <= IDLE;
              if (!rx_valid || rx_ready) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        WAIT_HIGH: begin
          if (rx_sync) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
